// File: rtl/uart_hello_check.sv
// Receive-side checker: compares UART RX bytes against an expected message held in block RAM.
// Define UART_HELLO_CHECK_CHECKSUM_EN to build the running 16-bit checksum of accepted bytes.

module blockram_512x8 #(
    parameter string INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       read_en,
    input  logic [8:0] read_addr,
    output logic [7:0] read_data,
    input  logic       write_en,
    input  logic [8:0] write_addr,
    input  logic [7:0] write_data
);
    logic [7:0] mem [512];

    always_ff @(posedge clk) begin
        if (write_en) mem[write_addr] <= write_data;
        if (read_en) read_data <= mem[read_addr];
    end
endmodule

module uart_hello_check #(
    parameter int unsigned MESSAGE_LEN = 512,
    parameter string       INIT_FILE   = "obj/message2.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    input  logic        restart,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic        first_err_valid,
    output logic [8:0]  first_err_index,
    output logic        overrun,
    output logic [15:0] checksum
);
    localparam logic [8:0] LastIdx = 9'(MESSAGE_LEN - 1);

    typedef enum logic [0:0] {StRun, StDone} state_e;

    state_e     state_q;
    logic [8:0] cursor_q;
    logic [8:0] mem_read_addr;
    logic [7:0] mem_read_data;
    logic       mem_read_en;
    logic       mem_write_en;
    logic [8:0] mem_write_addr;
    logic [7:0] mem_write_data;
    logic       accept;
    logic       mismatch;
    logic       at_last;

    assign mem_read_en    = 1'b1;
    assign mem_write_en   = 1'b0;
    assign mem_write_addr = 9'd0;
    assign mem_write_data = 8'd0;

    assign accept   = rx_valid && !restart && (state_q == StRun);
    assign mismatch = rx_error || (rx_data != mem_read_data);
    assign at_last  = (cursor_q == LastIdx);

    // Address tracks the cursor value being loaded so read data lines up one cycle later.
    always_comb begin
        mem_read_addr = cursor_q;
        if (rst || restart) begin
            mem_read_addr = 9'd0;
        end else if (accept && !at_last) begin
            mem_read_addr = cursor_q + 9'd1;
        end
    end

    blockram_512x8 #(
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk        (clk),
        .read_en    (mem_read_en),
        .read_addr  (mem_read_addr),
        .read_data  (mem_read_data),
        .write_en   (mem_write_en),
        .write_addr (mem_write_addr),
        .write_data (mem_write_data)
    );

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state_q         <= StRun;
            cursor_q        <= 9'd0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 16'd0;
            first_err_valid <= 1'b0;
            first_err_index <= 9'd0;
            overrun         <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (rx_valid) begin
                        if (mismatch) begin
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_index <= cursor_q;
                            end
                        end
                        if (at_last) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            pass    <= !first_err_valid && !mismatch;
                        end else begin
                            cursor_q <= cursor_q + 9'd1;
                        end
                    end
                end
                StDone: begin
                    if (rx_valid) overrun <= 1'b1;
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef UART_HELLO_CHECK_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            checksum <= 16'd0;
        end else if (accept) begin
            checksum <= checksum + {8'd0, rx_data};
        end
    end
`else
    assign checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_uart_hello_check.sv
// Directed/randomised bench for uart_hello_check with a message-level reference model.
module tb_uart_hello_check;
    localparam int Len = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rx_valid, rx_error, restart;
    logic [7:0]  rx_data;
    logic        done, pass, first_err_valid, overrun;
    logic [15:0] err_count, checksum;
    logic [8:0]  first_err_index;

    logic        s_rst, s_rx_valid, s_rx_error, s_restart;
    logic [7:0]  s_rx_data;
    logic        s_done, s_pass, s_first_err_valid, s_overrun;
    logic [15:0] s_err_count, s_checksum;
    logic [8:0]  s_first_err_index;

    uart_hello_check #(.MESSAGE_LEN(Len), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .restart(restart), .done(done), .pass(pass), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_index(first_err_index),
        .overrun(overrun), .checksum(checksum)
    );

    uart_hello_check #(.MESSAGE_LEN(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(s_rst), .rx_valid(s_rx_valid), .rx_data(s_rx_data),
        .rx_error(s_rx_error), .restart(s_restart), .done(s_done), .pass(s_pass),
        .err_count(s_err_count), .first_err_valid(s_first_err_valid),
        .first_err_index(s_first_err_index), .overrun(s_overrun), .checksum(s_checksum)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_msg   [Len];
    logic [7:0] sent_data [Len];
    bit         sent_err  [Len];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: outcome of a pass after the first n bytes of sent_* have been accepted.
    task automatic model(input int n, output int errs, output int first, output bit fev,
                         output logic [15:0] sum, output bit dn, output bit ps);
        errs = 0; first = 0; fev = 0; sum = 16'd0;
        for (int i = 0; i < n; i++) begin
            if (sent_err[i] || sent_data[i] != exp_msg[i]) begin
                if (!fev) first = i;
                fev = 1;
                errs++;
            end
            sum = sum + 16'(sent_data[i]);
        end
        dn = (n == Len);
        ps = dn && (errs == 0);
    endtask

    task automatic check_state(input string tag, input int n, input bit ovr);
        int errs, first;
        bit fev, dn, ps;
        logic [15:0] sum;
        model(n, errs, first, fev, sum, dn, ps);
        check({tag, "/done"}, 32'(done), 32'(dn));
        check({tag, "/pass"}, 32'(pass), 32'(ps));
        check({tag, "/err_count"}, 32'(err_count), 32'(errs));
        check({tag, "/first_err_valid"}, 32'(first_err_valid), 32'(fev));
        check({tag, "/first_err_index"}, 32'(first_err_index), 32'(first));
        check({tag, "/overrun"}, 32'(overrun), 32'(ovr));
`ifdef UART_HELLO_CHECK_CHECKSUM_EN
        check({tag, "/checksum"}, 32'(checksum), 32'(sum));
`else
        check({tag, "/checksum"}, 32'(checksum), 32'h0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit e);
        rx_valid = 1'b1; rx_data = d; rx_error = e;
        tick();
        rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'($urandom);
    endtask

    // Idle cycles; with noise, rx_error toggles without rx_valid and must be ignored.
    task automatic idle(input int n, input bit noise);
        for (int k = 0; k < n; k++) begin
            rx_error = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            rx_data  = 8'($urandom);
            tick();
        end
        rx_error = 1'b0;
    endtask

    task automatic set_clean();
        for (int i = 0; i < Len; i++) begin
            sent_data[i] = exp_msg[i];
            sent_err[i]  = 1'b0;
        end
    endtask

    task automatic send_msg(input string tag, input int gap, input bit noise);
        for (int i = 0; i < Len; i++) begin
            if (i == Len - 1) check_state({tag, "/before_last"}, i, 1'b0);
            send(sent_data[i], sent_err[i]);
            if (i < Len - 1) idle(gap, noise);
        end
        check_state(tag, Len, 1'b0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'd0;
        s_rst = 1'b1; s_restart = 1'b0; s_rx_valid = 1'b0; s_rx_error = 1'b0; s_rx_data = 8'd0;
        for (int i = 0; i < Len; i++) begin
            exp_msg[i] = 8'($urandom);
            dut.u_ram.mem[i] <= exp_msg[i];
        end
        dut1.u_ram.mem[0] <= 8'h48;
        repeat (3) tick();
        rst = 1'b0; s_rst = 1'b0;

        set_clean();
        check_state("reset", 0, 1'b0);

        send_msg("clean_gap10", 9, 1'b1);

        pulse_restart();
        check_state("after_restart", 0, 1'b0);
        set_clean();
        sent_data[37] = exp_msg[37] ^ 8'h01;
        send_msg("corrupt37", 1, 1'b0);

        pulse_restart();
        set_clean();
        sent_err[0] = 1'b1;
        sent_err[511] = 1'b1;
        send_msg("framing", 2, 1'b0);

        pulse_restart();
        set_clean();
        send_msg("burst", 0, 1'b0);
        send(8'($urandom), 1'b1);
        check_state("overrun", Len, 1'b1);

        // Restart coinciding with a byte drops that byte.
        pulse_restart();
        set_clean();
        for (int i = 0; i < 100; i++) send(exp_msg[i], 1'b0);
        check_state("mid100", 100, 1'b0);
        restart = 1'b1; rx_valid = 1'b1; rx_data = 8'($urandom);
        tick();
        restart = 1'b0; rx_valid = 1'b0;
        check_state("restart_drop", 0, 1'b0);
        send_msg("after_restart_mid", 0, 1'b0);

        // Reset mid-message, also coinciding with a byte.
        pulse_restart();
        for (int i = 0; i < 50; i++) send(exp_msg[i] ^ 8'(i % 3 == 0), 1'b0);
        rst = 1'b1; rx_valid = 1'b1;
        tick();
        rst = 1'b0; rx_valid = 1'b0;
        set_clean();
        check_state("rst_mid", 0, 1'b0);

        for (int p = 0; p < 3; p++) begin
            pulse_restart();
            for (int i = 0; i < Len; i++) begin
                sent_data[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : exp_msg[i];
                sent_err[i]  = ($urandom_range(0, 15) == 0);
            end
            send_msg($sformatf("random%0d", p), $urandom_range(0, 3), 1'b1);
        end

        // MESSAGE_LEN = 1 instance.
        check(".short/reset_done", 32'(s_done), 32'h0);
        s_rx_valid = 1'b1; s_rx_data = 8'h48;
        tick();
        s_rx_valid = 1'b0;
        check("short/done", 32'(s_done), 32'h1);
        check("short/pass", 32'(s_pass), 32'h1);
        check("short/err_count", 32'(s_err_count), 32'h0);
`ifdef UART_HELLO_CHECK_CHECKSUM_EN
        check("short/checksum", 32'(s_checksum), 32'h48);
`else
        check("short/checksum", 32'(s_checksum), 32'h0);
`endif
        s_restart = 1'b1;
        tick();
        s_restart = 1'b0;
        check("short/restart_done", 32'(s_done), 32'h0);
        s_rx_valid = 1'b1; s_rx_data = 8'h49;
        tick();
        s_rx_data = 8'h48;
        check("short/bad_done", 32'(s_done), 32'h1);
        check("short/bad_pass", 32'(s_pass), 32'h0);
        check("short/bad_err", 32'(s_err_count), 32'h1);
        check("short/bad_fev", 32'(s_first_err_valid), 32'h1);
        check("short/bad_idx", 32'(s_first_err_index), 32'h0);
        check("short/no_overrun", 32'(s_overrun), 32'h0);
        tick();
        s_rx_valid = 1'b0;
        check("short/overrun", 32'(s_overrun), 32'h1);
        check("short/err_frozen", 32'(s_err_count), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
